// File: rtl/mul_pkg.sv
// Shared definitions for the 64-bit multiplier: widths, op encodings,
// Booth digit encoding and the stage-1 operand payload.
package mul_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PP_NUM = XLEN / 2;
    localparam int unsigned PP_W   = 2 * XLEN;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        MUL_OP_MUL    = 3'd0,
        MUL_OP_MULH   = 3'd1,
        MUL_OP_MULHSU = 3'd2,
        MUL_OP_MULHU  = 3'd3,
        MUL_OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_digit_e;

    // Extended operands held in the stage-1 register.
    typedef struct packed {
        logic [OP_W-1:0] op;      // raw op tag, forwarded unchanged
        logic [PP_W-1:0] x;       // multiplicand, sign/zero-extended to PP_W
        logic [XLEN-1:0] b;       // multiplier as seen by the Booth encoder
        logic            b_corr;  // b is unsigned with MSB set: fix up pp[PP_NUM-1]
    } mul_s1_t;

    // Radix-4 Booth digit for window {b[2j+1], b[2j], b[2j-1]}.
    function automatic booth_digit_e booth_decode(input logic [2:0] win);
        booth_digit_e d;
        case (win)
            3'b001, 3'b010: d = BOOTH_POS1;
            3'b011:         d = BOOTH_POS2;
            3'b100:         d = BOOTH_NEG2;
            3'b101, 3'b110: d = BOOTH_NEG1;
            default:        d = BOOTH_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_sel.sv
// One Booth partial-product selector.
//   win  : Booth window {b[2j+1], b[2j], b[2j-1]}
//   x    : extended multiplicand
//   pp_c : d*x mod 2^PP_W, fully negated (no separate +1 row)
module booth_sel
    import mul_pkg::*;
(
    input  logic [2:0]      win,
    input  logic [PP_W-1:0] x,
    output logic [PP_W-1:0] pp_c
);

    booth_digit_e digit;

    assign digit = booth_decode(win);

    always_comb begin
        pp_c = '0;
        case (digit)
            BOOTH_POS1: pp_c = x;
            BOOTH_POS2: pp_c = PP_W'(x << 1);
            BOOTH_NEG1: pp_c = PP_W'(-x);
            BOOTH_NEG2: pp_c = PP_W'(-(x << 1));
            default:    pp_c = '0;
        endcase
    end

endmodule

// File: rtl/mul_booth_pp_gen.sv
// Multiplier front end: operand register (S1) with per-op extension, then
// radix-4 Booth partial products registered in S2.
//   clk, rst_n           : clock, async active-low reset
//   flush                : kill all in-flight ops
//   in_valid/in_ready    : operand handshake (in_op, in_a, in_b)
//   out_valid/out_ready  : partial-product handshake (out_op, out_pp)
//   out_pp[j]            : unshifted pp j; the reduction tree applies << 2j
module mul_booth_pp_gen
    import mul_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [OP_W-1:0]                  in_op,
    input  logic [XLEN-1:0]                  in_a,
    input  logic [XLEN-1:0]                  in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OP_W-1:0]                  out_op,
    output logic [PP_NUM-1:0][PP_W-1:0]      out_pp
);

    logic    s1_valid;
    mul_s1_t s1_q;
    mul_s1_t s1_d;
    logic    s1_ready_c;
    logic    s2_ready_c;
    logic    s1_accept;
    logic    s2_load;

    logic [XLEN:0]                 b_win;
    logic [PP_NUM-1:0][PP_W-1:0]   pp_raw;
    logic [PP_NUM-1:0][PP_W-1:0]   pp_c;

    // Handshake: in_ready never depends on in_valid.
    assign s2_ready_c = !out_valid || out_ready;
    assign s1_ready_c = !s1_valid || s2_ready_c;
    assign in_ready   = s1_ready_c && !flush;
    assign s1_accept  = in_valid && in_ready;
    assign s2_load    = s1_valid && s2_ready_c && !flush;

    // Operand extension per op; unknown ops behave as MUL.
    always_comb begin
        s1_d        = '0;
        s1_d.op     = in_op;
        s1_d.x      = {{XLEN{in_a[XLEN-1]}}, in_a};
        s1_d.b      = in_b;
        s1_d.b_corr = 1'b0;
        case (in_op)
            MUL_OP_MULHSU: begin
                s1_d.b_corr = in_b[XLEN-1];
            end
            MUL_OP_MULHU: begin
                s1_d.x      = {{XLEN{1'b0}}, in_a};
                s1_d.b_corr = in_b[XLEN-1];
            end
            MUL_OP_MULW: begin
                s1_d.x = {{(PP_W-32){in_a[31]}}, in_a[31:0]};
                s1_d.b = {{(XLEN-32){in_b[31]}}, in_b[31:0]};
            end
            default: ;
        endcase
    end

    // S1 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_accept) begin
            s1_valid <= 1'b1;
        end else if (s2_ready_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 operand register, loads only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (s1_accept) begin
            s1_q <= s1_d;
        end
    end

    // b[-1] = 0 appended below the LSB.
    assign b_win = {s1_q.b, 1'b0};

    for (genvar gj = 0; gj < PP_NUM; gj++) begin : g_pp
        booth_sel u_sel (
            .win  (b_win[2*gj+2 -: 3]),
            .x    (s1_q.x),
            .pp_c (pp_raw[gj])
        );
    end

    // Unsigned b with MSB set: signed Booth read b as b - 2^XLEN, so add
    // x*2^XLEN back, i.e. x<<2 into the top row (which carries << 2*(PP_NUM-1)).
    always_comb begin
        pp_c = pp_raw;
        if (s1_q.b_corr) begin
            pp_c[PP_NUM-1] = PP_W'(pp_raw[PP_NUM-1] + PP_W'(s1_q.x << 2));
        end
    end

    // S2 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_ready_c) begin
            out_valid <= s1_valid;
        end
    end

    // S2 data register, loads only when an op moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_op <= '0;
            out_pp <= '0;
        end else if (s2_load) begin
            out_op <= s1_q.op;
            out_pp <= pp_c;
        end
    end

endmodule
